// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline demux datapath.
package pipe_pkg;

   localparam int unsigned DEMUX_DATA_W  = 8;
   localparam int unsigned DEMUX_MAX_OUT = 16;

   typedef logic [DEMUX_DATA_W-1:0] word_t;

endpackage

// File: rtl/demux_out_reg.sv
// Single-entry valid/data holding register for one demux output channel.
// The data register is cleared whenever the entry empties, so the output is zero-gated.
module demux_out_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEMUX_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // A load wins over a drain, giving one word per cycle when the consumer is always ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_demux.sv
// Registered 1-to-N demultiplexer with per-channel valid/ready and a one-word holding register.
// Optional broadcast input enabled by defining PIPE_DEMUX_BCAST_EN.
module pipe_demux
   import pipe_pkg::*;
#(
   parameter  int unsigned DATA_W = DEMUX_DATA_W,
   parameter  int unsigned N_OUT  = 2,
   localparam int unsigned SEL_W  = $clog2(N_OUT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [SEL_W-1:0]        in_sel,
`ifdef PIPE_DEMUX_BCAST_EN
   input  logic                    in_bcast,
`endif
   output logic [N_OUT-1:0]        out_valid,
   input  logic [N_OUT-1:0]        out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic                    sel_err
);

   if (N_OUT < 2 || N_OUT > DEMUX_MAX_OUT) begin : g_bad_n_out
      $error("pipe_demux: N_OUT out of legal range");
   end

   logic             w_bcast;
   logic             w_in_range;
   logic             w_sel_free;
   logic             w_xfer;
   logic [N_OUT-1:0] w_ch_valid;
   logic [N_OUT-1:0] w_ch_free;
   logic [N_OUT-1:0] w_load;
   logic             r_sel_err;

`ifdef PIPE_DEMUX_BCAST_EN
   assign w_bcast = in_bcast;
`else
   assign w_bcast = 1'b0;
`endif

   // A channel can accept when it is empty or being drained this cycle.
   assign w_ch_free = ~w_ch_valid | out_ready;

   // Select decode; an index with no matching channel leaves the word free to drop.
   always_comb begin
      w_in_range = 1'b0;
      w_sel_free = 1'b1;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         if (in_sel == SEL_W'(k)) begin
            w_in_range = 1'b1;
            w_sel_free = w_ch_free[k];
         end
      end
   end

   assign in_ready = w_bcast ? (&w_ch_free) : w_sel_free;
   assign w_xfer   = in_valid && in_ready;

   always_comb begin
      w_load = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
         w_load[k] = w_xfer && (w_bcast || (in_sel == SEL_W'(k)));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_xfer && !w_bcast && !w_in_range;
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_ch
      demux_out_reg #(
         .DATA_W (DATA_W)
      ) u_out_reg (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_load  (w_load[k]),
         .i_data  (in_data),
         .i_ready (out_ready[k]),
         .o_valid (w_ch_valid[k]),
         .o_data  (out_data[k*DATA_W +: DATA_W])
      );
   end

   assign out_valid = w_ch_valid;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_demux.sv
// Scoreboard bench for pipe_demux (N_OUT=3 so that an out-of-range select exists).
module tb_pipe_demux;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 8;
   localparam int unsigned SW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_data = '0;
   logic [SW-1:0]   in_sel = '0;
   logic            bcast = 1'b0;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready = '0;
   logic [N*W-1:0]  out_data;
   logic            sel_err;

   always #5 clk = ~clk;

   pipe_demux #(
      .DATA_W (W),
      .N_OUT  (N)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
`ifdef PIPE_DEMUX_BCAST_EN
      .in_bcast  (bcast),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_err   (sel_err)
   );

   // Expected word per channel and the cycle from which it must be visible.
   typedef struct packed {
      logic [7:0] d;
      int         avail;
   } exp_t;

   exp_t q [N][$];
   int   err_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic last_acc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: mid-cycle, compare every channel and sel_err against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < int'(N); k++) begin
            logic       ev;
            logic [7:0] ed;
            ev = (q[k].size() > 0) && (q[k][0].avail <= cyc);
            ed = ev ? q[k][0].d : 8'h00;
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(ev));
            check($sformatf("out_data[%0d]", k), 32'(out_data[k*W +: W]), 32'(ed));
            if (ev && out_ready[k]) void'(q[k].pop_front());
         end
         begin
            logic ee;
            ee = (err_q.size() > 0) && (err_q[0] == cyc);
            check("sel_err", 32'(sel_err), 32'(ee));
            if (ee) void'(err_q.pop_front());
         end
      end
   end

   // Driver: apply one cycle of stimulus, check in_ready, record what the DUT must deliver.
   task automatic step(input logic v, input logic [SW-1:0] sel, input logic [7:0] d,
                       input logic [N-1:0] ordy, input logic bc);
      logic exp_rdy;
      @(posedge clk); #1;
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
      bcast     = bc;
      #1;
      if (bc) begin
         exp_rdy = 1'b1;
         for (int k = 0; k < int'(N); k++)
            if (q[k].size() != 0 && !ordy[k]) exp_rdy = 1'b0;
      end else if (int'(sel) < int'(N)) begin
         exp_rdy = (q[sel].size() == 0) || ordy[sel];
      end else begin
         exp_rdy = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      last_acc = v && exp_rdy;
      if (last_acc) begin
         if (bc) begin
            for (int k = 0; k < int'(N); k++) q[k].push_back('{d: d, avail: cyc + 1});
         end else if (int'(sel) < int'(N)) begin
            q[sel].push_back('{d: d, avail: cyc + 1});
         end else begin
            err_q.push_back(cyc + 1);
         end
      end
   endtask

   task automatic do_reset(input int ncyc);
      @(posedge clk); #1;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = '0;
      bcast     = 1'b0;
      for (int k = 0; k < int'(N); k++) q[k].delete();
      err_q.delete();
      repeat (ncyc) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic          pend;
      logic          pv;
      logic [SW-1:0] ps;
      logic [7:0]    pd;
      logic          pb;

      // Reset, then idle with all consumers ready.
      do_reset(3);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

      // Single word to channel 1.
      step(1'b1, 2'd1, 8'hA5, 3'b111, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

      // Stalled channel 0 holds its word; channel 1 keeps flowing.
      step(1'b1, 2'd0, 8'h11, 3'b110, 1'b0);
      step(1'b1, 2'd0, 8'h22, 3'b110, 1'b0);
      step(1'b1, 2'd1, 8'h33, 3'b110, 1'b0);
      repeat (3) step(1'b0, 2'd0, 8'h00, 3'b110, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

      // Back-to-back stream on channel 0.
      for (int i = 1; i <= 8; i++) step(1'b1, 2'd0, 8'(i), 3'b111, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

      // Out-of-range select is dropped with a one-cycle sel_err.
      step(1'b1, 2'd3, 8'hFF, 3'b111, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

      // Reset while channel 1 holds a word.
      step(1'b1, 2'd1, 8'h5A, 3'b000, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b000, 1'b0);
      do_reset(1);
      step(1'b0, 2'd1, 8'h00, 3'b111, 1'b0);

`ifdef PIPE_DEMUX_BCAST_EN
      // Broadcast waits for the stalled channel, then all channels load together.
      step(1'b1, 2'd0, 8'h44, 3'b110, 1'b0);
      repeat (2) step(1'b1, 2'd0, 8'hC3, 3'b110, 1'b1);
      step(1'b1, 2'd0, 8'hC3, 3'b111, 1'b1);
      step(1'b0, 2'd0, 8'h00, 3'b000, 1'b0);
      step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
`endif

      // Randomised traffic; an unaccepted word is held stable until it transfers.
      pend = 1'b0;
      pv = 1'b0; ps = '0; pd = '0; pb = 1'b0;
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] ordy;
         if (!pend) begin
            pv = ($urandom_range(3) != 0);
            ps = SW'($urandom_range(3));
            pd = 8'($urandom);
`ifdef PIPE_DEMUX_BCAST_EN
            pb = ($urandom_range(7) == 0);
`else
            pb = 1'b0;
`endif
         end
         for (int k = 0; k < int'(N); k++) ordy[k] = ($urandom_range(9) < 7);
         step(pv, ps, pd, ordy, pb);
         pend = pv && !last_acc;
      end

      repeat (4) step(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
      @(posedge clk); #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_demux.md
Name: pipe_demux

Overview:
Parametrised, registered 1-to-N demultiplexer for the 8-bit pipeline datapath. It is the successor of the combinational 1-to-2 data demux.
- Routes one input word to one of N_OUT output channels, selected by in_sel.
- Each channel has its own valid/ready handshake and a one-entry holding register, so a stalled consumer back-pressures only traffic aimed at that channel.
- Sits between a pipeline stage's result bus and its downstream consumers (register-file write port, memory-store path, ...).

Parameters:
- DATA_W, 8, width of the data word.
- N_OUT, 2, number of output channels; legal range 2..16.
- SEL_W, $clog2(N_OUT), select width; derived, never overridden.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  upstream may transfer this cycle.
- in_data  in  DATA_W  word to route.
- in_sel  in  SEL_W  destination channel index.
- out_valid  out  N_OUT  per-channel valid.
- out_ready  in  N_OUT  per-channel consumer ready.
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  out  1  one-cycle pulse: a word with out-of-range in_sel was dropped.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clock edge:
  - out_valid = 0, every channel's data = 0, sel_err = 0.
  - Held words are discarded. Reset mid-transfer loses the word without a partial output.
- in_ready is combinational:
  - in range (in_sel < N_OUT): in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - out of range: in_ready = 1.
  - Depends on in_sel and out_ready; upstream must hold in_sel stable while in_valid=1.
- Input transfer = in_valid && in_ready at the clock edge.
  - In-range transfer: channel in_sel loads in_data and sets its valid on that edge. Latency is 1 cycle from input transfer to out_valid.
  - Out-of-range transfer (only possible when N_OUT is not a power of 2): word dropped, sel_err=1 for the next cycle, no channel changes.
- Output transfer k = out_valid[k] && out_ready[k]. At that edge, channel k clears valid unless it is reloaded in the same cycle.
- Simultaneous drain and load of the same channel: the new word replaces the old one, valid stays 1. This gives 1 word/cycle per channel when the consumer is always ready.
- Non-selected channels hold their state. A held word persists indefinitely while out_ready[k]=0; data and valid must stay stable (no drop, no overwrite).
- Zero-gating: out_data for channel k reads 0 whenever out_valid[k]=0. This keeps the convention that an unselected output carries zero.
- No per-channel ordering hazards: each channel is FIFO of depth 1, and words to different channels are independent.
- in_valid=0 has no effect regardless of in_sel.

Optional Feature:
- Macro PIPE_DEMUX_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_sel is ignored and the word goes to all N_OUT channels at once.
  - in_ready = AND over k of (!out_valid[k] || out_ready[k]); all channels load on the same edge, so there is no partial broadcast.
  - sel_err is never raised for a broadcast.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package pipe_pkg:
  - default constant DEMUX_DATA_W = 8
  - typedef word_t (logic [7:0])
  - constant DEMUX_MAX_OUT = 16
- One sub-module, demux_out_reg: single-entry valid/data holding register with zero-gated output, instantiated N_OUT times in a generate loop.
- Top-level logic: select decode, in_ready mux, sel_err, broadcast.

Test Plan:
1. Reset then release, N_OUT=2: out_valid=2'b00, out_data=0, in_ready=1.
2. Send 8'hA5 with sel=1, all ready: out_valid=2'b10 next cycle, channel-1 data 8'hA5, channel-0 data 8'h00.
3. Hold out_ready[0]=0, send 8'h11 then 8'h22 to sel=0: second word sees in_ready=0 and 8'h11 holds. Meanwhile 8'h33 to sel=1 is accepted and delivered.
4. Stream 8'h01..8'h08 to sel=0 with out_ready[0]=1: one word per cycle, no bubbles, in order.
5. N_OUT=3, in_sel=3, in_data=8'hFF: in_ready=1, sel_err pulses one cycle, no out_valid rises.
6. rst_n=0 while channel 1 holds 8'h5A: out_valid=0 next edge. With PIPE_DEMUX_BCAST_EN, broadcasting 8'hC3 while one channel is stalled waits, then all channels present 8'hC3 together.
